// File: rtl/page_walker.sv
// Single-level page-table walker: turns a dTLB miss into one PTE read,
// then refills the dTLB or reports a page fault. Handles flush at every stage.
module page_walker #(
    parameter int VPN_W = 20,
    parameter int PPN_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ptbr,
    input  logic             miss_valid,
    input  logic [VPN_W-1:0] miss_vpn,
    output logic             miss_ready,
    input  logic             flush,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             write_en,
    output logic [VPN_W-1:0] write_vpn,
    output logic [PPN_W-1:0] write_ppn,
    output logic             fault,
    output logic [VPN_W-1:0] fault_vpn,
    output logic             busy,
    output logic [CNT_W-1:0] fill_cnt,
    output logic [CNT_W-1:0] fault_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FILL  = 3'd3,
        ST_FAULT = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [VPN_W-1:0]  vpn_r;
    logic [PPN_W-1:0]  ppn_r;
    logic [31:0]       addr_r;
    logic [CNT_W-1:0]  fill_cnt_r;
    logic [CNT_W-1:0]  fault_cnt_r;
    logic [31:0]       pte_off_s;
    logic              accept_s;
    logic              ppn_ld_s;
    logic              fill_inc_s;
    logic              fault_inc_s;
    logic              miss_ready_s;
    logic              mem_req_s;
    logic              write_en_s;
    logic              fault_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign pte_off_s = 32'({miss_vpn, 2'b00});

    // Next-state and control decode; outputs follow state and flush in the same
    // cycle so a flush can drop mem_req and suppress refill/fault immediately.
    always_comb begin
        state_s      = state_r;
        accept_s     = 1'b0;
        ppn_ld_s     = 1'b0;
        fill_inc_s   = 1'b0;
        fault_inc_s  = 1'b0;
        miss_ready_s = 1'b0;
        mem_req_s    = 1'b0;
        write_en_s   = 1'b0;
        fault_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                miss_ready_s = ~flush;
                if (miss_valid && !flush) begin
                    accept_s = 1'b1;
                    state_s  = ST_REQ;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_REQ: begin
                mem_req_s = ~flush;
                if (mem_gnt) begin
                    // a granted request must have its response drained
                    state_s = flush ? ST_DRAIN : ST_WAIT;
                end else if (flush) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    // flush coinciding with the response: nothing left to drain
                    if (flush) begin
                        state_s = ST_IDLE;
                    end else if (mem_rdata[31]) begin
                        ppn_ld_s = 1'b1;
                        state_s  = ST_FILL;
                    end else begin
                        state_s  = ST_FAULT;
                    end
                end else if (flush) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_FILL: begin
                state_s = ST_IDLE;
                if (!flush) begin
                    write_en_s = 1'b1;
                    fill_inc_s = 1'b1;
                end else begin
                    write_en_s = 1'b0;
                    fill_inc_s = 1'b0;
                end
            end
            ST_FAULT: begin
                state_s = ST_IDLE;
                if (!flush) begin
                    fault_s     = 1'b1;
                    fault_inc_s = 1'b1;
                end else begin
                    fault_s     = 1'b0;
                    fault_inc_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Walk context: VPN and PTE address captured at acceptance, PPN on valid PTE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vpn_r  <= {VPN_W{1'b0}};
            addr_r <= 32'd0;
            ppn_r  <= {PPN_W{1'b0}};
        end else begin
            if (accept_s) begin
                vpn_r  <= miss_vpn;
                addr_r <= ptbr + pte_off_s;
            end
            if (ppn_ld_s) begin
                ppn_r <= mem_rdata[PPN_W-1:0];
            end
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_cnt_r  <= {CNT_W{1'b0}};
            fault_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (fill_inc_s) begin
                fill_cnt_r <= sat_inc(fill_cnt_r);
            end
            if (fault_inc_s) begin
                fault_cnt_r <= sat_inc(fault_cnt_r);
            end
        end
    end

    assign miss_ready = miss_ready_s;
    assign mem_req    = mem_req_s;
    assign mem_addr   = addr_r;
    assign write_en   = write_en_s;
    assign write_vpn  = vpn_r;
    assign write_ppn  = ppn_r;
    assign fault      = fault_s;
    assign fault_vpn  = vpn_r;
    assign busy       = (state_r != ST_IDLE);
    assign fill_cnt   = fill_cnt_r;
    assign fault_cnt  = fault_cnt_r;

endmodule

// File: tb/tb_page_walker.sv
// Self-checking bench for page_walker: directed vector table, multi-cycle
// corner sequences, then randomized traffic against a transaction-level model.
module tb_page_walker;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ptbr;
    logic        miss_valid;
    logic [19:0] miss_vpn;
    logic        miss_ready;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        write_en;
    logic [19:0] write_vpn;
    logic [7:0]  write_ppn;
    logic        fault;
    logic [19:0] fault_vpn;
    logic        busy;
    logic [CW-1:0] fill_cnt;
    logic [CW-1:0] fault_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    page_walker #(.VPN_W(20), .PPN_W(8), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .ptbr(ptbr),
        .miss_valid(miss_valid), .miss_vpn(miss_vpn), .miss_ready(miss_ready),
        .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .write_en(write_en), .write_vpn(write_vpn), .write_ppn(write_ppn),
        .fault(fault), .fault_vpn(fault_vpn), .busy(busy),
        .fill_cnt(fill_cnt), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic quiet();
        miss_valid = 1'b0;
        flush      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    // drive a miss at the next negedge; caller checks acceptance
    task automatic offer(input logic [31:0] base, input logic [19:0] vpn);
        @(negedge clk);
        quiet();
        ptbr       = base;
        miss_vpn   = vpn;
        miss_valid = 1'b1;
        #1;
        check("accept_ready", 32'(miss_ready), 32'd1);
    endtask

    // one complete walk with immediate grant and response
    task automatic quick_fill(input logic [7:0] ppn);
        offer(32'h0000_4000, 20'h00001);
        @(negedge clk); quiet(); mem_gnt = 1'b1;
        @(negedge clk); quiet(); mem_rvalid = 1'b1; mem_rdata = {24'h800000, ppn};
        @(negedge clk); quiet();
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] ptbr;
        logic [19:0] vpn;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        is_fill;
        logic [7:0]  ppn;
        int          fills;
        int          faults;
    } vec_t;

    vec_t vecs[6];

    // transaction-level reference model state
    bit          m_want_gnt;
    bit          m_outstanding;
    bit          m_discard;
    int          m_result;   // 0 none, 1 refill due, 2 fault due
    logic [19:0] m_vpn;
    logic [7:0]  m_ppn;
    logic [31:0] m_addr;
    int          m_fills;
    int          m_faults;

    initial begin
        vecs[0] = '{32'h0000_1000, 20'h00003, 32'h8000_0042, 32'h0000_100C, 1'b1, 8'h42, 1, 0};
        vecs[1] = '{32'h0000_1000, 20'h00003, 32'h0000_0042, 32'h0000_100C, 1'b0, 8'h00, 1, 1};
        vecs[2] = '{32'hFFFF_FFF0, 20'h00008, 32'h8000_00A5, 32'h0000_0010, 1'b1, 8'hA5, 2, 1};
        vecs[3] = '{32'h0000_0000, 20'hFFFFF, 32'h8000_12FF, 32'h003F_FFFC, 1'b1, 8'hFF, 3, 1};
        vecs[4] = '{32'h1234_5678, 20'h00ABC, 32'h7FFF_FFFF, 32'h1234_8168, 1'b0, 8'h00, 3, 2};
        vecs[5] = '{32'h8000_0000, 20'h80001, 32'hFFFF_FF01, 32'h8020_0004, 1'b1, 8'h01, 4, 2};

        rst = 1'b0; ptbr = 32'd0; miss_vpn = 20'd0; mem_rdata = 32'd0;
        quiet();
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_write_en", 32'(write_en), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_fill_cnt", 32'(fill_cnt), 32'd0);
        check("rst_fault_cnt", 32'(fault_cnt), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_after_reset", 32'(miss_ready), 32'd1);

        // directed table: minimum-latency walks
        for (int i = 0; i < 6; i++) begin
            offer(vecs[i].ptbr, vecs[i].vpn);
            check("accept_no_req", 32'(mem_req), 32'd0);
            @(negedge clk); quiet(); mem_gnt = 1'b1; ptbr = 32'hDEAD_BEEF; miss_vpn = 20'h5A5A5;
            #1;
            check("req_c1", 32'(mem_req), 32'd1);
            check("addr_c1", mem_addr, vecs[i].addr);
            check("ready_c1", 32'(miss_ready), 32'd0);
            @(negedge clk); quiet(); mem_rvalid = 1'b1; mem_rdata = vecs[i].rdata;
            #1;
            check("req_c2", 32'(mem_req), 32'd0);
            check("busy_c2", 32'(busy), 32'd1);
            @(negedge clk); quiet();
            #1;
            check("write_en_c3", 32'(write_en), 32'(vecs[i].is_fill));
            check("fault_c3", 32'(fault), 32'(!vecs[i].is_fill));
            if (vecs[i].is_fill) begin
                check("write_vpn_c3", 32'(write_vpn), 32'(vecs[i].vpn));
                check("write_ppn_c3", 32'(write_ppn), 32'(vecs[i].ppn));
            end else begin
                check("fault_vpn_c3", 32'(fault_vpn), 32'(vecs[i].vpn));
            end
            @(negedge clk);
            #1;
            check("ready_c4", 32'(miss_ready), 32'd1);
            check("fill_cnt", 32'(fill_cnt), 32'(vecs[i].fills));
            check("fault_cnt", 32'(fault_cnt), 32'(vecs[i].faults));
            check("write_en_c4", 32'(write_en), 32'd0);
        end

        // grant held off for five cycles
        offer(32'h0000_2000, 20'h11111);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); quiet();
            #1;
            check("gnt_wait_req", 32'(mem_req), 32'd1);
            check("gnt_wait_addr", mem_addr, 32'h0004_6444);
            check("gnt_wait_ready", 32'(miss_ready), 32'd0);
        end
        @(negedge clk); quiet(); mem_gnt = 1'b1;
        #1;
        check("gnt_late_req", 32'(mem_req), 32'd1);
        @(negedge clk); quiet(); mem_rvalid = 1'b1; mem_rdata = 32'h8000_0033;
        @(negedge clk); quiet();
        #1;
        check("late_write_en", 32'(write_en), 32'd1);
        check("late_write_ppn", 32'(write_ppn), 32'h33);

        // flush in WAIT, response three cycles later is drained
        offer(32'h0000_3000, 20'h00022);
        @(negedge clk); quiet(); mem_gnt = 1'b1;
        @(negedge clk); quiet(); flush = 1'b1;
        #1;
        check("flush_wait_ready", 32'(miss_ready), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); quiet();
            #1;
            check("drain_busy", 32'(busy), 32'd1);
            check("drain_ready", 32'(miss_ready), 32'd0);
        end
        @(negedge clk); quiet(); mem_rvalid = 1'b1; mem_rdata = 32'h8000_0077;
        #1;
        check("drain_rvalid_ready", 32'(miss_ready), 32'd0);
        @(negedge clk); quiet();
        #1;
        check("drain_done_ready", 32'(miss_ready), 32'd1);
        check("drain_no_write", 32'(write_en), 32'd0);
        check("drain_no_fault", 32'(fault), 32'd0);
        check("drain_fill_cnt", 32'(fill_cnt), 32'd5);
        check("drain_fault_cnt", 32'(fault_cnt), 32'd2);

        // fill counter saturates
        for (int k = 0; k < 12; k++) quick_fill(8'(k));
        #1;
        check("fill_cnt_sat", 32'(fill_cnt), 32'(CMAX));

        // reset during REQ, stray response afterwards
        offer(32'h0000_5000, 20'h00044);
        @(negedge clk); quiet(); rst = 1'b0;
        #1;
        check("rst_req_mem_req", 32'(mem_req), 32'd0);
        check("rst_req_busy", 32'(busy), 32'd0);
        check("rst_req_fill_cnt", 32'(fill_cnt), 32'd0);
        @(negedge clk); rst = 1'b1;
        #1;
        check("rst_release_ready", 32'(miss_ready), 32'd1);
        @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h8000_0011;
        @(negedge clk); quiet();
        #1;
        check("stray_no_write", 32'(write_en), 32'd0);
        check("stray_no_busy", 32'(busy), 32'd0);

        // randomized traffic against the model
        m_want_gnt = 1'b0; m_outstanding = 1'b0; m_discard = 1'b0; m_result = 0;
        m_vpn = 20'd0; m_ppn = 8'd0; m_addr = 32'd0; m_fills = 0; m_faults = 0;
        for (int c = 0; c < 3000; c++) begin
            bit m_busy;
            @(negedge clk);
            miss_valid = ($urandom_range(0, 1) == 0);
            miss_vpn   = 20'($urandom);
            ptbr       = $urandom;
            flush      = ($urandom_range(0, 19) == 0);
            mem_gnt    = ($urandom_range(0, 4) < 2);
            mem_rvalid = ($urandom_range(0, 9) < 3);
            mem_rdata  = $urandom;
            #1;
            m_busy = m_want_gnt || m_outstanding || (m_result != 0);
            check("r_busy", 32'(busy), 32'(m_busy));
            check("r_miss_ready", 32'(miss_ready), 32'(!m_busy && !flush));
            check("r_mem_req", 32'(mem_req), 32'(m_want_gnt && !flush));
            check("r_write_en", 32'(write_en), 32'(m_result == 1 && !flush));
            check("r_fault", 32'(fault), 32'(m_result == 2 && !flush));
            if (m_want_gnt) check("r_mem_addr", mem_addr, m_addr);
            if (m_result == 1 && !flush) begin
                check("r_write_vpn", 32'(write_vpn), 32'(m_vpn));
                check("r_write_ppn", 32'(write_ppn), 32'(m_ppn));
            end
            if (m_result == 2 && !flush) check("r_fault_vpn", 32'(fault_vpn), 32'(m_vpn));
            check("r_fill_cnt", 32'(fill_cnt), 32'(m_fills));
            check("r_fault_cnt", 32'(fault_cnt), 32'(m_faults));

            // advance the model by one clock using the inputs just applied
            if (m_result != 0) begin
                if (!flush && m_result == 1 && m_fills < CMAX) m_fills++;
                if (!flush && m_result == 2 && m_faults < CMAX) m_faults++;
                m_result = 0;
            end else if (m_want_gnt) begin
                if (mem_gnt) begin
                    m_want_gnt    = 1'b0;
                    m_outstanding = 1'b1;
                    m_discard     = flush;
                end else if (flush) begin
                    m_want_gnt = 1'b0;
                end
            end else if (m_outstanding) begin
                if (mem_rvalid) begin
                    m_outstanding = 1'b0;
                    if (!m_discard && !flush) begin
                        m_result = mem_rdata[31] ? 1 : 2;
                        if (mem_rdata[31]) m_ppn = mem_rdata[7:0];
                    end
                    m_discard = 1'b0;
                end else if (flush) begin
                    m_discard = 1'b1;
                end
            end else if (miss_valid && !flush) begin
                m_vpn      = miss_vpn;
                m_addr     = ptbr + 32'(miss_vpn) * 32'd4;
                m_want_gnt = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/page_walker.md
PAGE_WALKER -- requirements
Module: page_walker

Interface
REQ-001 Parameter VPN_W, default 20: virtual page number width, matches vpn_t.
REQ-002 Parameter PPN_W, default 8: physical page number width, matches ppn_t.
REQ-003 Parameter CNT_W, default 16: width of statistics counters.
REQ-004 Port clk  in  1: single clock; all state updates on posedge clk.
REQ-005 Port rst  in  1: reset, asynchronous, active-low.
REQ-006 Port ptbr  in  32: page-table base address, byte address.
REQ-007 Port miss_valid  in  1: dTLB miss pending.
REQ-008 Port miss_vpn  in  VPN_W: VPN that missed.
REQ-009 Port miss_ready  out  1: walker accepts a miss this cycle.
REQ-010 Port flush  in  1: abort any walk and discard its result.
REQ-011 Port mem_req  out  1: PTE read request.
REQ-012 Port mem_addr  out  32: PTE byte address.
REQ-013 Port mem_gnt  in  1: memory accepted the request.
REQ-014 Port mem_rvalid  in  1: read data valid.
REQ-015 Port mem_rdata  in  32: PTE; bit 31 = valid, bits [PPN_W-1:0] = PPN.
REQ-016 Port write_en / write_vpn / write_ppn  out  1 / VPN_W / PPN_W: dTLB refill.
REQ-017 Port fault / fault_vpn  out  1 / VPN_W: page-fault pulse and faulting VPN.
REQ-018 Port busy  out  1: state other than IDLE.
REQ-019 Port fill_cnt / fault_cnt  out  CNT_W / CNT_W: completed refills / faults.

Function
REQ-020 States: IDLE, REQ, WAIT, FILL, FAULT, DRAIN.
REQ-021 miss_ready SHALL equal (state==IDLE) and not flush.
REQ-022 IDLE: on miss_valid and miss_ready, latch miss_vpn and ptbr and go to REQ.
REQ-023 mem_addr SHALL be latched ptbr + {vpn, 2'b00}, truncated modulo 2^32.
REQ-024 REQ: mem_req=1 with a stable mem_addr; mem_gnt=1 goes to WAIT. mem_req is asserted the cycle after acceptance.
REQ-025 WAIT: mem_rvalid=1 with rdata[31]=1 latches PPN and goes to FILL; with rdata[31]=0 goes to FAULT.
REQ-026 FILL: write_en=1 for exactly one cycle, write_vpn = latched VPN, write_ppn = latched PPN, fill_cnt increments, next state IDLE.
REQ-027 FAULT: fault=1 for exactly one cycle, fault_vpn = latched VPN, fault_cnt increments, next state IDLE.
REQ-028 Minimum latency: acceptance at cycle 0, gnt at 1, rvalid at 2, write_en at 3, miss_ready at 4.
REQ-029 mem_rvalid outside WAIT/DRAIN SHALL be ignored; mem_gnt outside REQ SHALL be ignored.
REQ-030 flush in IDLE or REQ goes to IDLE next cycle; mem_req drops immediately that cycle; no memory transaction is left pending.
REQ-031 flush in WAIT goes to DRAIN; DRAIN waits for mem_rvalid, discards the data, then goes to IDLE; miss_ready stays 0 throughout.
REQ-032 flush in FILL or FAULT suppresses write_en and fault that cycle, leaves both counters unchanged, and goes to IDLE.
REQ-033 flush and mem_gnt together in REQ go to DRAIN, because the transaction was issued.
REQ-034 Counters saturate at all-ones and SHALL NOT wrap.
REQ-035 write_en, fault, mem_req and busy SHALL be mutually consistent with state; there is no combinational path from miss_valid to mem_req.

Reset
REQ-036 rst low SHALL force IDLE asynchronously; mem_req=0, write_en=0, fault=0, busy=0, fill_cnt=0, fault_cnt=0, latched vpn/ppn/addr=0.
REQ-037 Reset mid-walk abandons the transaction; any mem_rvalid after reset release while in IDLE is ignored per REQ-029.
REQ-038 miss_ready SHALL be 1 in the first cycle after reset release when flush=0.

Verification
REQ-039 ptbr=0x1000, miss_vpn=0x00003, gnt immediate, rdata=0x8000_0042 -> mem_addr=0x100C; write_en pulses at cycle 3 with vpn=0x00003, ppn=0x42; fill_cnt=1.
REQ-040 rdata=0x0000_0042 -> fault pulses once with fault_vpn=0x00003; no write_en; fault_cnt=1.
REQ-041 gnt delayed 5 cycles -> mem_req held 5 cycles with constant mem_addr; miss_ready=0 throughout.
REQ-042 flush in WAIT, rvalid 3 cycles later -> DRAIN, no write_en or fault, miss_ready returns the cycle after rvalid.
REQ-043 ptbr=0xFFFF_FFF0, vpn=0x00008 -> mem_addr=0x0000_0010 (wrap); 2^CNT_W+1 fills -> fill_cnt stays 0xFFFF.
REQ-044 rst asserted during REQ -> mem_req=0 immediately; stray rvalid after release produces no write_en.
